// File: rtl/pc16_seq.sv
// ---------------------------------------------------------------------------
// pc16_seq -- 16-bit program counter for the Hack-style CPU datapath.
//
// Takes the jump/call target produced by the gate/ALU stage and produces the
// registered instruction address. Supports hold, increment, load and
// synchronous reset, plus an optional call/return address stack.
//
// Optional feature macro: PC_RET_STACK_EN
//   defined   : LIFO return stack of DEPTH entries; call pushes out+1 and
//               jumps, ret pops into out; stk_empty/stk_full/err are live.
//   undefined : no stack storage; call acts exactly as load, ret is ignored,
//               stk_empty=1, stk_full=0, err=0 constantly.
//   The port list is identical in both builds.
//
// Parameters
//   WIDTH     address width; bit 0 is the MSB, bit WIDTH-1 is the LSB
//   DEPTH     return-stack entries (power of 2, 2..16)
//   RESET_VAL value of out after reset
//
// Ports
//   clock      in   1      single clock, all state changes on posedge
//   reset      in   1      synchronous active-high reset, overrides all
//   in         in   WIDTH  jump/call target
//   load       in   1      out <= in
//   inc        in   1      out <= out + 1 (wraps, no flag)
//   call       in   1      push out+1, out <= in
//   ret        in   1      out <= popped stack top
//   out        out  WIDTH  current address (registered)
//   stk_empty  out  1      stack holds 0 entries (registered)
//   stk_full   out  1      stack holds DEPTH entries (registered)
//   err        out  1      sticky overflow/underflow flag, cleared by reset
//
// Per-edge priority: reset > ret > call > load > inc > hold.
// ---------------------------------------------------------------------------
module pc16_seq #(
    parameter int                WIDTH     = 16,
    parameter int                DEPTH     = 4,
    parameter logic [0:WIDTH-1]  RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [0:WIDTH-1] in,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    output logic [0:WIDTH-1] out,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             err
);

    logic [0:WIDTH-1] out_reg;
    logic [0:WIDTH-1] out_next;
    logic [0:WIDTH-1] out_inc;

    // Shared by inc and by the call return address; wraps modulo 2^WIDTH.
    assign out_inc = out_reg + WIDTH'(1);
    assign out     = out_reg;

`ifdef PC_RET_STACK_EN

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so sp can represent DEPTH (full) without wrapping.
    localparam int SPW = AW + 1;

    // Small register-based stack: ret must place the top entry on out at the
    // very next edge, so the read is taken combinationally from the array and
    // captured by out_reg.
    logic [0:WIDTH-1] stack_mem [0:DEPTH-1];

    logic [SPW-1:0] sp_reg;
    logic [SPW-1:0] sp_next;
    logic           empty_reg;
    logic           full_reg;
    logic           err_reg;
    logic           err_next;
    logic           push_en;
    logic [AW-1:0]  push_idx;
    logic [AW-1:0]  top_idx;

    assign push_idx = AW'(sp_reg);
    assign top_idx  = AW'(sp_reg - SPW'(1));

    always_comb begin
        out_next = out_reg;
        sp_next  = sp_reg;
        err_next = err_reg;
        push_en  = 1'b0;
        if (reset) begin
            out_next = RESET_VAL;
            sp_next  = '0;
            err_next = 1'b0;
        end else if (ret) begin
            if (!empty_reg) begin
                out_next = stack_mem[top_idx];
                sp_next  = sp_reg - SPW'(1);
            end else begin
                // Underflow: out holds, sp stays at 0.
                err_next = 1'b1;
            end
        end else if (call) begin
            out_next = in;
            if (!full_reg) begin
                push_en = 1'b1;
                sp_next = sp_reg + SPW'(1);
            end else begin
                // Overflow: the jump still happens, the stack is untouched.
                err_next = 1'b1;
            end
        end else if (load) begin
            out_next = in;
        end else if (inc) begin
            out_next = out_inc;
        end
    end

    always_ff @(posedge clock) begin
        out_reg   <= out_next;
        sp_reg    <= sp_next;
        err_reg   <= err_next;
        // Flags derived from the next pointer so they change in step with sp.
        empty_reg <= (sp_next == '0);
        full_reg  <= (sp_next == SPW'(DEPTH));
    end

    // Storage is never reset; only entries below sp are ever read.
    always_ff @(posedge clock) begin
        if (push_en) begin
            stack_mem[push_idx] <= out_inc;
        end
    end

    assign stk_empty = empty_reg;
    assign stk_full  = full_reg;
    assign err       = err_reg;

`else

    // ret has no effect in this build; the name keeps it out of unused lint.
    logic unused_ret;
    assign unused_ret = ret;

    always_comb begin
        out_next = out_reg;
        if (reset) begin
            out_next = RESET_VAL;
        end else if (call || load) begin
            out_next = in;
        end else if (inc) begin
            out_next = out_inc;
        end
    end

    always_ff @(posedge clock) begin
        out_reg <= out_next;
    end

    assign stk_empty = 1'b1;
    assign stk_full  = 1'b0;
    assign err       = 1'b0;

`endif

endmodule

// File: tb/tb_pc16_seq.sv
// ---------------------------------------------------------------------------
// tb_pc16_seq -- self-checking bench for pc16_seq.
// A table of single-cycle vectors covers reset, inc, wrap, load priority and
// hold; hand-written sequences cover the multi-cycle stack behaviour (or the
// stackless behaviour when PC_RET_STACK_EN is undefined).
// ---------------------------------------------------------------------------
module tb_pc16_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [0:15] din   = '0;
    logic        load  = 1'b0;
    logic        inc   = 1'b0;
    logic        call  = 1'b0;
    logic        ret   = 1'b0;
    logic [0:15] dout;
    logic        stk_empty;
    logic        stk_full;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pc16_seq #(.WIDTH(16), .DEPTH(4), .RESET_VAL(16'h0000)) dut (
        .clock     (clock),
        .reset     (reset),
        .in        (din),
        .load      (load),
        .inc       (inc),
        .call      (call),
        .ret       (ret),
        .out       (dout),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .err       (err)
    );

    typedef struct {
        string       name;
        logic        r;
        logic        ld;
        logic        ic;
        logic        cl;
        logic        rt;
        logic [15:0] d;
        logic [15:0] exp_out;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one set of controls for exactly one clock edge, then sample 1ns later.
    task automatic cyc(input logic r, input logic ld, input logic ic,
                       input logic cl, input logic rt, input logic [15:0] d);
        reset = r; load = ld; inc = ic; call = cl; ret = rt; din = d;
        @(posedge clock);
        #1;
        reset = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic expect_state(input string name, input logic [15:0] eo,
                                input logic ee, input logic ef, input logic er);
        $display("txn %-12s out=%h empty=%b full=%b err=%b", name, dout, stk_empty, stk_full, err);
        chk({name, ".out"},   dout,             eo);
        chk({name, ".empty"}, {15'd0, stk_empty}, {15'd0, ee});
        chk({name, ".full"},  {15'd0, stk_full},  {15'd0, ef});
        chk({name, ".err"},   {15'd0, err},       {15'd0, er});
    endtask

    initial begin
        //          name          r   ld  ic  cl  rt  in        out       e  f  err
        vecs[0]  = '{"rst_wins",  1, 1, 0, 0, 0, 16'h1234, 16'h0000, 1, 0, 0};
        vecs[1]  = '{"inc1",      0, 0, 1, 0, 0, 16'h0000, 16'h0001, 1, 0, 0};
        vecs[2]  = '{"inc2",      0, 0, 1, 0, 0, 16'h0000, 16'h0002, 1, 0, 0};
        vecs[3]  = '{"inc3",      0, 0, 1, 0, 0, 16'h0000, 16'h0003, 1, 0, 0};
        vecs[4]  = '{"ld_ffff",   0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 0, 0};
        vecs[5]  = '{"inc_wrap",  0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0};
        vecs[6]  = '{"ld_beats",  0, 1, 1, 0, 0, 16'h0100, 16'h0100, 1, 0, 0};
        vecs[7]  = '{"hold",      0, 0, 0, 0, 0, 16'h0000, 16'h0100, 1, 0, 0};
        vecs[8]  = '{"ld_abcd",   0, 1, 0, 0, 0, 16'hABCD, 16'hABCD, 1, 0, 0};
        vecs[9]  = '{"inc_abce",  0, 0, 1, 0, 0, 16'h0000, 16'hABCE, 1, 0, 0};
        vecs[10] = '{"hold_in",   0, 0, 0, 0, 0, 16'h5555, 16'hABCE, 1, 0, 0};
        vecs[11] = '{"rst_inc",   1, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0};
        vecs[12] = '{"ld_8000",   0, 1, 0, 0, 0, 16'h8000, 16'h8000, 1, 0, 0};
        vecs[13] = '{"inc_8001",  0, 0, 1, 0, 0, 16'h0000, 16'h8001, 1, 0, 0};

        @(negedge clock);
        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].r, vecs[i].ld, vecs[i].ic, vecs[i].cl, vecs[i].rt, vecs[i].d);
            expect_state(vecs[i].name, vecs[i].exp_out, vecs[i].exp_empty,
                         vecs[i].exp_full, vecs[i].exp_err);
        end

`ifdef PC_RET_STACK_EN
        // Nested call/return.
        cyc(1, 0, 0, 0, 0, 16'h0000);
        cyc(0, 1, 0, 0, 0, 16'h0010);
        expect_state("n_ld",   16'h0010, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 16'h0200);
        expect_state("n_call1", 16'h0200, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 16'h0300);
        expect_state("n_call2", 16'h0300, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        expect_state("n_ret1", 16'h0201, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        expect_state("n_ret2", 16'h0011, 1, 0, 0);

        // Overflow / underflow with DEPTH=4.
        cyc(1, 0, 0, 0, 0, 16'h0000);
        cyc(0, 0, 0, 1, 0, 16'h1000);
        expect_state("o_call1", 16'h1000, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 16'h2000);
        cyc(0, 0, 0, 1, 0, 16'h3000);
        expect_state("o_call3", 16'h3000, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 16'h4000);
        expect_state("o_call4", 16'h4000, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 16'h5000);
        expect_state("o_call5", 16'h5000, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        expect_state("o_ret1", 16'h3001, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        expect_state("o_ret2", 16'h2001, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        expect_state("o_ret3", 16'h1001, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        expect_state("o_ret4", 16'h0001, 1, 0, 1);
        cyc(0, 0, 1, 0, 1, 16'h0000);
        expect_state("o_ret5", 16'h0001, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 16'h0000);
        expect_state("o_sticky", 16'h0001, 1, 0, 1);

        // Reset beats a ret with two entries stacked.
        cyc(1, 0, 0, 0, 0, 16'h0000);
        cyc(0, 0, 0, 1, 0, 16'h0100);
        cyc(0, 0, 0, 1, 0, 16'h0200);
        expect_state("r_two", 16'h0200, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 16'h0000);
        expect_state("r_ret", 16'h0000, 1, 0, 0);
`else
        // Stackless build: call is a load, ret is ignored and falls through.
        cyc(1, 0, 0, 0, 0, 16'h0000);
        cyc(0, 0, 0, 1, 0, 16'h0040);
        expect_state("s_call",    16'h0040, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        expect_state("s_ret",     16'h0040, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, 16'h0000);
        expect_state("s_ret_inc", 16'h0041, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 16'h0777);
        expect_state("s_ret_ld",  16'h0777, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 16'h0123);
        expect_state("s_call_inc", 16'h0123, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 0, 16'h0A00 + 16'(i));
        end
        expect_state("s_5calls",  16'h0A04, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        expect_state("s_ret_emp", 16'h0A04, 1, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
